// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit
// Description : RV32 M-extension multiply/divide unit. Single-cycle multiply
//               stage, 32-iteration restoring divider, one-cycle special
//               cases for divide-by-zero and signed overflow.
// Revision    : 1.0  initial release
// ============================================================================
module mdu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int            CW        = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] C_LAST    = CW'(XLEN);
  localparam logic [XLEN-1:0] C_MINNEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;        // funct3[1:0]; funct3[2] is implied by the state
  logic [XLEN-1:0] a_q, a_d;          // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0] b_q, b_d;          // multiplier, or divisor magnitude
  logic [XLEN-1:0] rem_q, rem_d;      // partial remainder
  logic [CW-1:0]   cnt_q, cnt_d;      // completed divide iterations
  logic            negq_q, negq_d;    // quotient needs negation
  logic            negr_q, negr_d;    // remainder needs negation
  logic [XLEN-1:0] result_q, result_d;

  logic              mul_sa, mul_sb;
  logic [2*XLEN-1:0] product;
  logic [XLEN:0]     div_shift, div_sub;
  logic              div_ge;
  logic              div_signed;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Next-state, datapath and result selection
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    result_d   = result_q;
    div_signed = ~funct3_i[0];

    // MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed
    mul_sa  = (op_q == 2'b01 || op_q == 2'b10) ? a_q[XLEN-1] : 1'b0;
    mul_sb  = (op_q == 2'b01) ? b_q[XLEN-1] : 1'b0;
    product = $signed({{XLEN{mul_sa}}, a_q}) * $signed({{XLEN{mul_sb}}, b_q});

    // One restoring step; a set top bit of the shifted remainder already exceeds any divisor
    div_shift = {rem_q, a_q[XLEN-1]};
    div_sub   = div_shift - {1'b0, b_q};
    div_ge    = div_shift[XLEN] | ~div_sub[XLEN];

    quo_fix = negq_q ? -a_q : a_q;
    rem_fix = negr_q ? -rem_q : rem_q;

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          op_d = funct3_i[1:0];
          if (!funct3_i[2]) begin
            a_d     = rs1_i;
            b_d     = rs2_i;
            state_d = S_MUL;
          end else if (rs2_i == '0) begin
            result_d = funct3_i[1] ? rs1_i : '1;
            state_d  = S_DONE;
          end else if (div_signed && rs1_i == C_MINNEG && rs2_i == '1) begin
            result_d = funct3_i[1] ? '0 : C_MINNEG;
            state_d  = S_DONE;
          end else begin
            a_d     = (div_signed && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
            b_d     = (div_signed && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
            rem_d   = '0;
            cnt_d   = '0;
            negq_d  = div_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
            negr_d  = div_signed & rs1_i[XLEN-1];
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        result_d = (op_q == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        state_d  = S_DONE;
      end
      S_DIV: begin
        if (cnt_q == C_LAST) begin
          result_d = op_q[1] ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end else begin
          rem_d = div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0];
          a_d   = {a_q[XLEN-2:0], div_ge};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides acceptance and result handshake alike
    if (flush_i) state_d = S_IDLE;
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign ready_o        = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign result_valid_o = (state_q == S_DONE);
  assign result_o       = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_unit
// Description : Directed self-checking bench for mdu_unit.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  mdu_unit #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .funct3_i       (funct3_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .flush_i        (flush_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure latency, optionally backpressure, then consume
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int hold);
    int n;
    bit busy_ok;
    bit stable;
    logic [31:0] held;
    n = 0;
    while (!ready_o && n < 100) begin tick(); n++; end
    valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b;
    tick();
    valid_i = 1'b0; funct3_i = ~f3; rs1_i = ~a; rs2_i = 32'h0;
    n = 1; busy_ok = 1'b1;
    while (!result_valid_o && n < 60) begin
      if (!busy_o || ready_o) busy_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, {32'h0, result_o}, {32'h0, exp_res});
    check({tag, " busy"}, {63'h0, busy_ok & busy_o}, 64'h1);
    if (hold > 0) begin
      held = result_o; stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        valid_i = 1'b1; funct3_i = F_DIVU; rs1_i = 32'h1234; rs2_i = 32'h0;
        tick();
        if (!result_valid_o || result_o !== held || ready_o) stable = 1'b0;
      end
      valid_i = 1'b0;
      check({tag, " held stable"}, {63'h0, stable}, 64'h1);
    end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check({tag, " ready after consume"}, {62'h0, ready_o, result_valid_o}, 64'h2);
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; valid_i = 1'b0; funct3_i = 3'b0; rs1_i = 32'h0; rs2_i = 32'h0;
    flush_i = 1'b0; result_ready_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset ready", {63'h0, ready_o}, 64'h1);
    check("reset busy", {63'h0, busy_o}, 64'h0);
    check("reset valid", {63'h0, result_valid_o}, 64'h0);
    check("reset result", {32'h0, result_o}, 64'h0);

    // Multiply family
    run_op("MUL 7x6",       F_MUL,    32'd7,        32'd6,        32'd42,        2, 0);
    run_op("MUL -1x2",      F_MUL,    32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,  2, 0);
    run_op("MULH min^2",    F_MULH,   32'h80000000, 32'h80000000, 32'h40000000,  2, 0);
    run_op("MULHSU -1xmax", F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,  2, 0);
    run_op("MULHU max^2",   F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  2, 0);

    // Iterative division
    run_op("DIV -7/2",      F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0);
    run_op("REM -7/2",      F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0);
    run_op("DIV 20/-3",     F_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 34, 0);
    run_op("REM 20/-3",     F_REM,    32'd20,       32'hFFFFFFFD, 32'd2,        34, 0);
    run_op("REMU 100/7",    F_REMU,   32'd100,      32'd7,        32'd2,        34, 0);
    run_op("DIVU max/1",    F_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34, 0);

    // Special cases
    run_op("DIVU 5/0",      F_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF,  1, 0);
    run_op("REM 5/0",       F_REM,    32'd5,        32'd0,        32'd5,         1, 0);
    run_op("DIV ovf",       F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1, 0);
    run_op("REM ovf",       F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000,  1, 0);

    // Backpressure with ignored requests while not ready
    run_op("MULHU bp",      F_MULHU,  32'h00010000, 32'h00030000, 32'h00000003,  2, 10);

    // Flush on iteration 15 of DIVU
    valid_i = 1'b1; funct3_i = F_DIVU; rs1_i = 32'd100; rs2_i = 32'd7;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush idle", {61'h0, ready_o, busy_o, result_valid_o}, 64'h4);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); if (result_valid_o) seen = 1'b1; end
    check("flush no result", {63'h0, seen}, 64'h0);

    // Flush wins over result_ready in DONE
    valid_i = 1'b1; funct3_i = F_MUL; rs1_i = 32'd3; rs2_i = 32'd3;
    tick();
    valid_i = 1'b0;
    tick();
    check("done before flush", {63'h0, result_valid_o}, 64'h1);
    flush_i = 1'b1; result_ready_i = 1'b1;
    tick();
    flush_i = 1'b0; result_ready_i = 1'b0;
    check("flush in done", {61'h0, ready_o, busy_o, result_valid_o}, 64'h4);

    // Reset during a signed divide, then a normal divide
    valid_i = 1'b1; funct3_i = F_DIV; rs1_i = 32'hFFFFFFF9; rs2_i = 32'd2;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    check("mid reset flags", {61'h0, ready_o, busy_o, result_valid_o}, 64'h4);
    check("mid reset result", {32'h0, result_o}, 64'h0);
    rst_n = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); if (result_valid_o) seen = 1'b1; end
    check("reset no result", {63'h0, seen}, 64'h0);
    run_op("DIVU 100/7",    F_DIVU,   32'd100,      32'd7,        32'd14,       34, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
